// File: rtl/mini16_pkg.sv
// Shared definitions for the mini16 UART arbiter: FSM state encoding and the index-width helper.
// The helper is a constant function, so parameter lists can use it to size ports.
package mini16_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Bits needed to hold an index in 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mini16_rr_pick.sv
// Rotating-priority pick: first set request at or above ptr, wrapping from REQ_N-1 to 0.
// Purely combinational (zero latency); no flow control of its own.
module mini16_rr_pick
    import mini16_pkg::*;
#(
    parameter  int REQ_N = 4,
    localparam int IDW   = clog2(REQ_N)
) (
    input  logic [REQ_N-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        int cand;
        cand = 0;
        idx  = '0;
        any  = |req;
        for (int off = REQ_N - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= REQ_N) begin
                cand = cand - REQ_N;
            end
            if (req[cand]) begin
                idx = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/mini16_uart_arb.sv
// Round-robin arbiter sharing one UART TX byte channel; a grant is held for a whole message.
// First byte 1 cycle after req_valid, then bytes pass combinationally; tx_ready goes straight to the owner's req_ready.
// MINI16_UART_ARB_TIMEOUT_EN compiles in an idle counter that revokes a stalled lock after TIMEOUT cycles.
module mini16_uart_arb
    import mini16_pkg::*;
#(
    parameter  int REQ_N      = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int TIMEOUT    = 1024,
    localparam int IDW        = clog2(REQ_N)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [REQ_N-1:0]            req_valid,
    input  logic [REQ_N*DATA_WIDTH-1:0] req_data,
    input  logic [REQ_N-1:0]            req_last,
    output logic [REQ_N-1:0]            req_ready,
    output logic                        tx_valid,
    output logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_ready,
    output logic [IDW-1:0]              grant_id,
    output logic                        busy
);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic [IDW-1:0] next_ptr;

`ifdef MINI16_UART_ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT);
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
`endif

    mini16_rr_pick #(
        .REQ_N (REQ_N)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign next_ptr = (grant_q == IDW'(REQ_N - 1)) ? '0 : grant_q + 1'b1;
    assign grant_id = grant_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

`ifdef MINI16_UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    // Outputs decode from the state flop only, so reset silences them without a clock edge.
    always_comb begin
        int base;
        base      = int'(grant_q) * DATA_WIDTH;
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        busy      = (state_q == ARB_LOCKED);
`ifdef MINI16_UART_ARB_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                tx_valid           = req_valid[grant_q];
                tx_data            = tx_valid ? req_data[base +: DATA_WIDTH] : '0;
                req_ready[grant_q] = tx_ready;
                if (tx_valid && tx_ready && req_last[grant_q]) begin
                    state_d = ARB_IDLE;
                    rr_d    = next_ptr;
                end
`ifdef MINI16_UART_ARB_TIMEOUT_EN
                // A bubble counts toward revocation; any valid cycle restarts the count.
                if (tx_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
                    idle_cnt_d = '0;
                    state_d    = ARB_IDLE;
                    rr_d       = next_ptr;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mini16_uart_arb.sv
// Directed bench for mini16_uart_arb: per-requester byte sources, expected-transfer queue, negedge monitor.
module tb_mini16_uart_arb;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;

    xfer_t       exp_q[$];
    logic [8:0]  src_mem [4][32];
    int          wr_p [4];
    int          rd_p [4];
    logic [3:0]  hold = 4'b0;
    int          n_total = 0;
    int          n_pass  = 0;

    mini16_uart_arb #(
        .REQ_N      (4),
        .DATA_WIDTH (8),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int id, input logic [7:0] d, input logic last);
        src_mem[id][wr_p[id]] = {last, d};
        wr_p[id]++;
    endtask

    task automatic expect_x(input logic [1:0] id, input logic [7:0] d);
        exp_q.push_back({id, d});
    endtask

    task automatic clear_sources();
        for (int i = 0; i < 4; i++) begin
            rd_p[i] = 0;
            wr_p[i] = 0;
        end
    endtask

    task automatic wait_lock(input logic [1:0] id, input string nm);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy && grant_id == id) break;
        end
        check(nm, {31'b0, busy && grant_id == id}, 1);
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check(nm, exp_q.size(), 0);
    endtask

    // Sources: sample handshake at negedge, advance and drive just after the rising edge.
    initial begin
        logic [3:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && rd_p[i] < wr_p[i]) rd_p[i]++;
                if (!hold[i] && rd_p[i] < wr_p[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = src_mem[i][rd_p[i]][7:0];
                    req_last[i]        = src_mem[i][rd_p[i]][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted byte must match the next expected transfer.
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL xfer_unexpected: got id %0d data 0x%0h required no transfer", grant_id, tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_id", {30'b0, grant_id}, {30'b0, e.id});
                        check("xfer_data", {24'b0, tx_data}, {24'b0, e.data});
                    end
                end
                if (!tx_valid) check("data_zero_when_invalid", {24'b0, tx_data}, 0);
                check("ready_mask", {28'b0, req_ready}, busy ? {28'b0, 4'(tx_ready) << grant_id} : 32'b0);
                if (!busy) check("valid_low_in_idle", {31'b0, tx_valid}, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int   fall;
        logic saw;
        logic stable;
        logic [7:0] first_data;

        // Reset state, visible before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_tx_valid", {31'b0, tx_valid}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_req_ready", {28'b0, req_ready}, 0);
        check("rst_grant_id", {30'b0, grant_id}, 0);
        tick();
        tick();
        reset = 1'b0;

        // Single requester, three-byte message, one-cycle first-byte latency.
        tx_ready = 1'b1;
        tick();
        load(2, 8'h41, 1'b0); load(2, 8'h42, 1'b0); load(2, 8'h43, 1'b1);
        expect_x(2, 8'h41); expect_x(2, 8'h42); expect_x(2, 8'h43);
        @(negedge clk);
        @(negedge clk);
        check("lat_valid_cycle_tx_low", {31'b0, tx_valid}, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("burst_tx_valid", {31'b0, tx_valid}, 1);
        end
        @(negedge clk);
        check("busy_drops_after_last", {31'b0, busy}, 0);
        // Pointer now at 3: requester 3 beats requester 0.
        tick();
        load(0, 8'hA0, 1'b1); load(3, 8'hA3, 1'b1);
        expect_x(3, 8'hA3); expect_x(0, 8'hA0);
        wait_drain("drain_rr_ptr3");

        // All four valid from reset: order 0,1,2,3,0.
        tick();
        reset = 1'b1;
        clear_sources();
        tick();
        reset = 1'b0;
        load(0, 8'hB0, 1'b1); load(1, 8'hB1, 1'b1); load(2, 8'hB2, 1'b1);
        load(3, 8'hB3, 1'b1); load(0, 8'hC0, 1'b1);
        expect_x(0, 8'hB0); expect_x(1, 8'hB1); expect_x(2, 8'hB2);
        expect_x(3, 8'hB3); expect_x(0, 8'hC0);
        wait_drain("drain_all_four");

        // Requester 0 waits for requester 1's message; 2 idle so 0 is next.
        tick();
        load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b0); load(1, 8'h13, 1'b1);
        expect_x(1, 8'h11); expect_x(1, 8'h12); expect_x(1, 8'h13); expect_x(0, 8'h01);
        wait_lock(1, "lock_req1");
        tick();
        load(0, 8'h01, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(busy && grant_id == 2'd1)) break;
            saw = saw | req_ready[0];
        end
        check("req0_ready_held_low", {31'b0, saw}, 0);
        wait_drain("drain_wait_then_0");

        // Same, but with 2 also waiting: 2 goes before 0.
        tick();
        load(1, 8'h21, 1'b0); load(1, 8'h22, 1'b1);
        expect_x(1, 8'h21); expect_x(1, 8'h22); expect_x(2, 8'h32); expect_x(0, 8'h31);
        wait_lock(1, "lock_req1_again");
        tick();
        load(0, 8'h31, 1'b1); load(2, 8'h32, 1'b1);
        wait_drain("drain_wait_then_2");

        // Backpressure: ten stalled cycles, data stable, no ready pulses.
        tick();
        tx_ready = 1'b0;
        load(3, 8'h51, 1'b0); load(3, 8'h52, 1'b1);
        expect_x(3, 8'h51); expect_x(3, 8'h52);
        wait_lock(3, "lock_req3");
        stable = 1'b1;
        saw    = 1'b0;
        first_data = tx_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stable = stable & (tx_data == 8'h51) & (tx_data == first_data);
            saw    = saw | (|req_ready);
        end
        check("stall_data_stable", {31'b0, stable}, 1);
        check("stall_no_ready", {31'b0, saw}, 0);
        tick();
        tx_ready = 1'b1;
        wait_drain("drain_after_stall");

        // Locked requester goes quiet: timeout revokes on the 16th idle cycle, or never.
        tick();
        tx_ready = 1'b0;
        load(0, 8'h61, 1'b0); load(0, 8'h62, 1'b1);
        expect_x(0, 8'h61); expect_x(0, 8'h62);
        wait_lock(0, "lock_req0");
        tick();
        hold[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!req_valid[0]) break;
        end
        fall = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (!busy && fall == 0) fall = k;
        end
`ifdef MINI16_UART_ARB_TIMEOUT_EN
        check("timeout_busy_fall_cycle", fall, 16);
`else
        check("no_timeout_busy_held", fall, 0);
`endif
        tick();
        hold[0]  = 1'b0;
        tx_ready = 1'b1;
        wait_drain("drain_after_bubble");

        // Async reset mid-message: outputs drop before the next edge; restart from requester 0.
        tick();
        tx_ready = 1'b0;
        load(2, 8'h71, 1'b0); load(2, 8'h72, 1'b0); load(2, 8'h73, 1'b1);
        wait_lock(2, "lock_req2");
        check("pre_reset_tx_valid", {31'b0, tx_valid}, 1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_tx_valid", {31'b0, tx_valid}, 0);
        check("async_rst_busy", {31'b0, busy}, 0);
        check("async_rst_req_ready", {28'b0, req_ready}, 0);
        clear_sources();
        tick();
        tick();
        reset    = 1'b0;
        tx_ready = 1'b1;
        load(1, 8'h81, 1'b1); load(0, 8'h80, 1'b1);
        expect_x(0, 8'h80); expect_x(1, 8'h81);
        wait_drain("drain_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mini16_uart_arb.md
MINI16_UART_ARB -- requirements
Module: mini16_uart_arb

Interface
REQ-001 Parameter REQ_N, default 4, SHALL set the number of requesters sharing one UART TX byte channel (legal range 2..16).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the byte width.
REQ-003 Parameter TIMEOUT, default 1024, SHALL set the idle-cycle limit before a locked grant is revoked.
REQ-004 clk  input  1  SHALL be the single clock for the whole block.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 req_valid  input  REQ_N  SHALL carry the per-requester byte-valid flags.
REQ-007 req_data  input  REQ_N*DATA_WIDTH  SHALL carry the per-requester bytes, requester i in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  REQ_N  SHALL mark the final byte of a message.
REQ-009 req_ready  output  REQ_N  SHALL carry the per-requester accept flags.
REQ-010 tx_valid  output  1  SHALL be the byte valid flag to the UART transmitter.
REQ-011 tx_data  output  DATA_WIDTH  SHALL be the byte to the UART transmitter.
REQ-012 tx_ready  input  1  SHALL indicate the UART transmitter accepts a byte.
REQ-013 grant_id  output  clog2(REQ_N)  SHALL give the index of the current owner.
REQ-014 busy  output  1  SHALL be high while in state LOCKED.

Function
REQ-015 The block SHALL have two states: IDLE and LOCKED.
REQ-016 In IDLE with any req_valid high, the block SHALL pick the first asserted requester searching upward from rr_ptr, wrapping from REQ_N-1 to 0, register it in grant_id, and enter LOCKED on the next edge.
REQ-017 In IDLE, tx_valid and req_ready SHALL be all zero; first-byte latency from req_valid to tx_valid SHALL be exactly 1 cycle.
REQ-018 In LOCKED, tx_valid SHALL equal req_valid[grant_id] and tx_data SHALL equal the granted slice combinationally; req_ready[grant_id] SHALL equal tx_ready; all other req_ready bits SHALL be 0.
REQ-019 A transfer SHALL occur only when tx_valid && tx_ready in the same cycle.
REQ-020 A transfer with req_last[grant_id]=1 SHALL return the block to IDLE and set rr_ptr to grant_id+1 modulo REQ_N.
REQ-021 The grant SHALL never change mid-message; a request from another requester raised during LOCKED SHALL wait.
REQ-022 A requester deasserting req_valid while locked SHALL hold the lock (bubble allowed) unless the timeout fires (REQ-028).
REQ-023 When requesters win simultaneously, the block SHALL break the tie strictly by rr_ptr order; starvation SHALL be impossible (worst-case wait of REQ_N-1 messages).
REQ-024 tx_data SHALL be 0 whenever tx_valid is 0.

Reset
REQ-025 While reset is high, the block SHALL set state=IDLE, rr_ptr=0, grant_id=0, and the timeout counter to 0; tx_valid, busy, and req_ready SHALL be 0 immediately, without waiting for a clock edge.
REQ-026 A reset during LOCKED SHALL abandon the partial message; no byte SHALL be emitted until a fresh arbitration after reset deasserts.

Configuration
REQ-027 The macro MINI16_UART_ARB_TIMEOUT_EN SHALL select whether the timeout logic is compiled in.
REQ-028 With MINI16_UART_ARB_TIMEOUT_EN defined: in LOCKED, a counter SHALL increment on each cycle with req_valid[grant_id]=0 and clear on each cycle with req_valid[grant_id]=1; on reaching TIMEOUT it SHALL force IDLE, set rr_ptr=grant_id+1, and clear to 0.
REQ-029 Without MINI16_UART_ARB_TIMEOUT_EN: no counter SHALL exist, and the lock SHALL release only on a req_last transfer.

Structure
REQ-030 The shared package mini16_pkg SHALL hold the state encoding constants (ARB_IDLE=0, ARB_LOCKED=1) and the clog2 helper function.
REQ-031 The rotating priority search SHALL be one sub-module, mini16_rr_pick (inputs: request vector and pointer; outputs: index and any-flag), purely combinational.
REQ-032 All flops SHALL sit in mini16_uart_arb.

Verification
REQ-033 Reset then single requester: req 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with tx_ready=1 -> tx_valid is first high 1 cycle after req_valid, then 3 consecutive transfers, busy drops, rr_ptr=3.
REQ-034 All 4 requesters valid with 1-byte messages from reset -> grant order is 0,1,2,3,0.
REQ-035 Req 1 locked mid-message, req 0 asserts -> req_ready[0] stays 0 until req 1's last byte transfers, then grant goes to 2 if valid, else to 0.
REQ-036 tx_ready held 0 for 10 cycles -> tx_data is stable, no req_ready pulse, and no byte is lost or duplicated.
REQ-037 With TIMEOUT_EN and TIMEOUT=16, the locked requester drops valid for 16 cycles -> busy falls exactly on cycle 16; without the macro, busy stays high indefinitely.
REQ-038 Reset asserted asynchronously mid-message -> tx_valid and busy go low before the next clk edge; after release, arbitration restarts from requester 0.
